parser_sequencer: RTL and testbench

PARSER_SEQUENCER -- requirements
Module: parser_sequencer

---
 rtl/parser_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_parser_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parser_sequencer.sv
// -----------------------------------------------------------------------------
// parser_sequencer
//
// Collects three-word ITCH frames from a word stream and presents them to a
// downstream parser as a stable register triple with a valid/ready handoff.
// A word flagged i_sof always starts a new frame. A partial frame interrupted
// by a new start-of-frame is dropped. Stray non-sof words seen while idle are
// also dropped.
//
// Optional feature (macro PARSER_SEQ_TIMEOUT_EN): a partial frame that sees
// no accepted word for TIMEOUT_CYCLES consecutive cycles is abandoned and
// counted as a drop. With the macro undefined, a partial frame waits
// indefinitely.
//
// Parameters
//   REG_WIDTH       width of message words and frame registers
//   TIMEOUT_CYCLES  idle-cycle limit inside a partial frame (macro builds only)
//
// Ports
//   i_clk           clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_data          incoming message word
//   i_valid         i_data valid
//   i_sof           i_data is the first word of a frame
//   o_ready         a word is accepted this cycle when i_valid is also high
//   o_reg_1..3      frame words 1..3
//   o_frame_valid   o_reg_1..3 hold a complete frame
//   i_frame_ready   parser consumes the presented frame
//   o_drop_cnt      saturating count of discarded words / aborted frames
//   o_frame_cnt     wrapping count of frames handed off
//
// State  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a start-of-frame word
// GOT1   | word 1 held, waiting for word 2
// GOT2   | words 1-2 held, waiting for word 3
// PRESENT| complete frame presented, waiting for i_frame_ready
// -----------------------------------------------------------------------------
module parser_sequencer #(
    parameter int REG_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [REG_WIDTH-1:0] i_data,
    input  logic                 i_valid,
    input  logic                 i_sof,
    output logic                 o_ready,
    output logic [REG_WIDTH-1:0] o_reg_1,
    output logic [REG_WIDTH-1:0] o_reg_2,
    output logic [REG_WIDTH-1:0] o_reg_3,
    output logic                 o_frame_valid,
    input  logic                 i_frame_ready,
    output logic [15:0]          o_drop_cnt,
    output logic [31:0]          o_frame_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GOT1    = 2'd1,
        GOT2    = 2'd2,
        PRESENT = 2'd3
    } state_t;

    // Elaboration-time sanity check on the timeout limit.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("parser_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

    state_t               state_q, state_d;
    logic [REG_WIDTH-1:0] reg1_q, reg1_d;
    logic [REG_WIDTH-1:0] reg2_q, reg2_d;
    logic [REG_WIDTH-1:0] reg3_q, reg3_d;
    logic [15:0]          drop_cnt_q, drop_cnt_d;
    logic [31:0]          frame_cnt_q, frame_cnt_d;
    logic                 accept;
    logic                 drop_inc;

`ifdef PARSER_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    assign accept = i_valid && (state_q != PRESENT);

    always_comb begin
        state_d     = state_q;
        reg1_d      = reg1_q;
        reg2_d      = reg2_q;
        reg3_d      = reg3_q;
        frame_cnt_d = frame_cnt_q;
        drop_inc    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (i_sof) begin
                        reg1_d  = i_data;
                        state_d = GOT1;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end
            GOT1, GOT2: begin
                if (accept) begin
                    if (i_sof) begin
                        // Resync on the new frame; the partial one is lost.
                        reg1_d   = i_data;
                        state_d  = GOT1;
                        drop_inc = 1'b1;
                    end else if (state_q == GOT1) begin
                        reg2_d  = i_data;
                        state_d = GOT2;
                    end else begin
                        reg3_d  = i_data;
                        state_d = PRESENT;
                    end
                end
            end
            PRESENT: begin
                if (i_frame_ready) begin
                    state_d     = IDLE;
                    frame_cnt_d = frame_cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef PARSER_SEQ_TIMEOUT_EN
        // Counts consecutive idle cycles inside a partial frame; the cycle
        // that would reach the limit abandons the frame.
        tmo_d = '0;
        if (((state_q == GOT1) || (state_q == GOT2)) && !accept) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d  = IDLE;
                drop_inc = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
`endif

        drop_cnt_d = drop_cnt_q;
        if (drop_inc && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            reg1_q      <= '0;
            reg2_q      <= '0;
            reg3_q      <= '0;
            drop_cnt_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            reg1_q      <= reg1_d;
            reg2_q      <= reg2_d;
            reg3_q      <= reg3_d;
            drop_cnt_q  <= drop_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

`ifdef PARSER_SEQ_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    // Pure state decodes: no combinational path from any input.
    assign o_ready       = (state_q != PRESENT);
    assign o_frame_valid = (state_q == PRESENT);
    assign o_reg_1       = reg1_q;
    assign o_reg_2       = reg2_q;
    assign o_reg_3       = reg3_q;
    assign o_drop_cnt    = drop_cnt_q;
    assign o_frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_parser_sequencer.sv
module tb_parser_sequencer;

    localparam int RW  = 32;
    localparam int TMO = 64;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic [RW-1:0] i_data = '0;
    logic          i_valid = 1'b0;
    logic          i_sof = 1'b0;
    logic          o_ready;
    logic [RW-1:0] o_reg_1, o_reg_2, o_reg_3;
    logic          o_frame_valid;
    logic          i_frame_ready = 1'b0;
    logic [15:0]   o_drop_cnt;
    logic [31:0]   o_frame_cnt;

    int n_cmp = 0;
    int n_err = 0;

    parser_sequencer #(.REG_WIDTH(RW), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_data        (i_data),
        .i_valid       (i_valid),
        .i_sof         (i_sof),
        .o_ready       (o_ready),
        .o_reg_1       (o_reg_1),
        .o_reg_2       (o_reg_2),
        .o_reg_3       (o_reg_3),
        .o_frame_valid (o_frame_valid),
        .i_frame_ready (i_frame_ready),
        .o_drop_cnt    (o_drop_cnt),
        .o_frame_cnt   (o_frame_cnt)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Helpers: tasks start and end 1 time unit after a rising edge.
    task automatic do_reset();
        i_valid = 1'b0;
        i_sof   = 1'b0;
        i_frame_ready = 1'b0;
        i_rst_n = 1'b0;
        #3;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [RW-1:0] d, input logic sof);
        i_data  = d;
        i_sof   = sof;
        i_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({o_reg_1, o_reg_2, o_reg_3} !== {3*RW{1'b0}} || o_frame_valid !== 1'b0 ||
            o_ready !== 1'b1 || o_drop_cnt !== 16'd0 || o_frame_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL reset_state: regs=%h/%h/%h fv=%b rdy=%b drop=%0d fcnt=%0d, expected 0/0/0 fv=0 rdy=1 drop=0 fcnt=0",
                     o_reg_1, o_reg_2, o_reg_3, o_frame_valid, o_ready, o_drop_cnt, o_frame_cnt);
        end
        do_reset();
        n_cmp++;
        if (o_ready !== 1'b1 || o_frame_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: rdy=%b fv=%b, expected rdy=1 fv=0", o_ready, o_frame_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        i_frame_ready = 1'b1;
        send(32'hA000_0001, 1'b1);
        send(32'h0000_0002, 1'b0);
        n_cmp++;
        if (o_frame_valid !== 1'b0 || o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_early_valid: fv=%b rdy=%b after 2 words, expected fv=0 rdy=1", o_frame_valid, o_ready);
        end
        send(32'h0000_0003, 1'b0);
        n_cmp++;
        if (o_frame_valid !== 1'b1 || o_ready !== 1'b0 || o_reg_1 !== 32'hA000_0001 ||
            o_reg_2 !== 32'h0000_0002 || o_reg_3 !== 32'h0000_0003) begin
            n_err++;
            $display("FAIL b2b_present: fv=%b rdy=%b regs=%h/%h/%h, expected fv=1 rdy=0 regs=a0000001/00000002/00000003",
                     o_frame_valid, o_ready, o_reg_1, o_reg_2, o_reg_3);
        end
        idle(1);
        n_cmp++;
        if (o_frame_valid !== 1'b0 || o_ready !== 1'b1 || o_frame_cnt !== 32'd1 || o_drop_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL b2b_handoff: fv=%b rdy=%b fcnt=%0d drop=%0d, expected fv=0 rdy=1 fcnt=1 drop=0",
                     o_frame_valid, o_ready, o_frame_cnt, o_drop_cnt);
        end
        // Second frame straight after: minimum 4-cycle period.
        send(32'h1111_1111, 1'b1);
        send(32'h2222_2222, 1'b0);
        send(32'h3333_3333, 1'b0);
        idle(1);
        n_cmp++;
        if (o_frame_cnt !== 32'd2 || o_reg_3 !== 32'h3333_3333 || o_frame_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_second: fcnt=%0d reg3=%h fv=%b, expected fcnt=2 reg3=33333333 fv=0",
                     o_frame_cnt, o_reg_3, o_frame_valid);
        end
        i_frame_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int bad;
        do_reset();
        i_frame_ready = 1'b0;
        send(32'hB000_0001, 1'b1);
        send(32'hB000_0002, 1'b0);
        send(32'hB000_0003, 1'b0);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            // Words offered while presenting must be ignored.
            i_data  = 32'hDEAD_0000 + c;
            i_sof   = c[0];
            i_valid = 1'b1;
            @(posedge i_clk);
            #1;
            if (o_frame_valid !== 1'b1 || o_ready !== 1'b0 || o_reg_1 !== 32'hB000_0001 ||
                o_reg_2 !== 32'hB000_0002 || o_reg_3 !== 32'hB000_0003) bad++;
        end
        i_valid = 1'b0;
        i_sof   = 1'b0;
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("FAIL bp_hold: %0d of 10 cycles with fv/rdy/regs=%b/%b/%h/%h/%h, expected 0 bad cycles (1/0/b0000001/b0000002/b0000003)",
                     bad, o_frame_valid, o_ready, o_reg_1, o_reg_2, o_reg_3);
        end
        n_cmp++;
        if (o_frame_cnt !== 32'd0 || o_drop_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL bp_counts_held: fcnt=%0d drop=%0d, expected fcnt=0 drop=0", o_frame_cnt, o_drop_cnt);
        end
        i_frame_ready = 1'b1;
        idle(1);
        i_frame_ready = 1'b0;
        n_cmp++;
        if (o_frame_valid !== 1'b0 || o_ready !== 1'b1 || o_frame_cnt !== 32'd1 || o_reg_1 !== 32'hB000_0001) begin
            n_err++;
            $display("FAIL bp_release: fv=%b rdy=%b fcnt=%0d reg1=%h, expected fv=0 rdy=1 fcnt=1 reg1=b0000001",
                     o_frame_valid, o_ready, o_frame_cnt, o_reg_1);
        end
    endtask

    task automatic test_drop_resync();
        do_reset();
        send(32'h0000_0011, 1'b0);
        n_cmp++;
        if (o_drop_cnt !== 16'd1 || o_reg_1 !== 32'd0) begin
            n_err++;
            $display("FAIL drop_idle: drop=%0d reg1=%h, expected drop=1 reg1=00000000", o_drop_cnt, o_reg_1);
        end
        send(32'h0000_0021, 1'b1);
        send(32'h0000_0022, 1'b0);
        send(32'h0000_0031, 1'b1);
        send(32'h0000_0032, 1'b0);
        send(32'h0000_0033, 1'b0);
        n_cmp++;
        if (o_drop_cnt !== 16'd2 || o_frame_valid !== 1'b1 || o_reg_1 !== 32'h31 ||
            o_reg_2 !== 32'h32 || o_reg_3 !== 32'h33) begin
            n_err++;
            $display("FAIL drop_resync: drop=%0d fv=%b regs=%h/%h/%h, expected drop=2 fv=1 regs=00000031/00000032/00000033",
                     o_drop_cnt, o_frame_valid, o_reg_1, o_reg_2, o_reg_3);
        end
        // Resync from GOT1 (sof directly after sof).
        i_frame_ready = 1'b1;
        idle(1);
        i_frame_ready = 1'b0;
        send(32'h0000_0041, 1'b1);
        send(32'h0000_0051, 1'b1);
        n_cmp++;
        if (o_drop_cnt !== 16'd3 || o_reg_1 !== 32'h51 || o_reg_2 !== 32'h32) begin
            n_err++;
            $display("FAIL drop_resync_got1: drop=%0d reg1=%h reg2=%h, expected drop=3 reg1=00000051 reg2=00000032",
                     o_drop_cnt, o_reg_1, o_reg_2);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send(32'hC000_0001, 1'b1);
`ifdef PARSER_SEQ_TIMEOUT_EN
        idle(TMO - 1);
        n_cmp++;
        if (o_drop_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL tmo_not_yet: drop=%0d after %0d idle cycles, expected 0", o_drop_cnt, TMO - 1);
        end
        idle(1);
        n_cmp++;
        if (o_drop_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL tmo_fire: drop=%0d after %0d idle cycles, expected 1", o_drop_cnt, TMO);
        end
        // Back in IDLE: a non-sof word is now a stray drop.
        send(32'hC000_0002, 1'b0);
        n_cmp++;
        if (o_drop_cnt !== 16'd2 || o_reg_2 !== 32'd0) begin
            n_err++;
            $display("FAIL tmo_idle: drop=%0d reg2=%h, expected drop=2 reg2=00000000", o_drop_cnt, o_reg_2);
        end
        do_reset();
        send(32'hC100_0001, 1'b1);
        idle(TMO - 1);
        send(32'hC100_0002, 1'b0);
        idle(TMO - 1);
        send(32'hC100_0003, 1'b0);
        n_cmp++;
        if (o_frame_valid !== 1'b1 || o_drop_cnt !== 16'd0 || o_reg_3 !== 32'hC100_0003) begin
            n_err++;
            $display("FAIL tmo_just_in_time: fv=%b drop=%0d reg3=%h, expected fv=1 drop=0 reg3=c1000003",
                     o_frame_valid, o_drop_cnt, o_reg_3);
        end
`else
        idle(3 * TMO);
        send(32'hC000_0002, 1'b0);
        send(32'hC000_0003, 1'b0);
        n_cmp++;
        if (o_frame_valid !== 1'b1 || o_drop_cnt !== 16'd0 || o_reg_1 !== 32'hC000_0001 || o_reg_3 !== 32'hC000_0003) begin
            n_err++;
            $display("FAIL no_timeout_wait: fv=%b drop=%0d reg1=%h reg3=%h, expected fv=1 drop=0 reg1=c0000001 reg3=c0000003",
                     o_frame_valid, o_drop_cnt, o_reg_1, o_reg_3);
        end
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        i_frame_ready = 1'b1;
        send(32'hD000_0001, 1'b1);
        send(32'hD000_0002, 1'b0);
        send(32'hD000_0003, 1'b0);
        idle(1);
        i_frame_ready = 1'b0;
        send(32'hD000_0009, 1'b0);
        send(32'hE000_0001, 1'b1);
        send(32'hE000_0002, 1'b0);
        n_cmp++;
        if (o_frame_cnt !== 32'd1 || o_drop_cnt !== 16'd1 || o_reg_1 !== 32'hE000_0001) begin
            n_err++;
            $display("FAIL arst_setup: fcnt=%0d drop=%0d reg1=%h, expected fcnt=1 drop=1 reg1=e0000001",
                     o_frame_cnt, o_drop_cnt, o_reg_1);
        end
        #3;
        i_rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({o_reg_1, o_reg_2, o_reg_3} !== {3*RW{1'b0}} || o_frame_valid !== 1'b0 ||
            o_ready !== 1'b1 || o_drop_cnt !== 16'd0 || o_frame_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL arst_immediate: regs=%h/%h/%h fv=%b rdy=%b drop=%0d fcnt=%0d, expected all 0, rdy=1",
                     o_reg_1, o_reg_2, o_reg_3, o_frame_valid, o_ready, o_drop_cnt, o_frame_cnt);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        send(32'hE000_0003, 1'b0);
        n_cmp++;
        if (o_frame_valid !== 1'b0 || o_drop_cnt !== 16'd1 || o_reg_3 !== 32'd0) begin
            n_err++;
            $display("FAIL arst_frame_discarded: fv=%b drop=%0d reg3=%h, expected fv=0 drop=1 reg3=00000000",
                     o_frame_valid, o_drop_cnt, o_reg_3);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        force dut.drop_cnt_q = 16'hFFFE;
        #1;
        release dut.drop_cnt_q;
        send(32'h0000_0001, 1'b0);
        n_cmp++;
        if (o_drop_cnt !== 16'hFFFF) begin
            n_err++;
            $display("FAIL sat_reach: drop=%h, expected ffff", o_drop_cnt);
        end
        send(32'h0000_0002, 1'b0);
        n_cmp++;
        if (o_drop_cnt !== 16'hFFFF) begin
            n_err++;
            $display("FAIL sat_hold: drop=%h, expected ffff", o_drop_cnt);
        end
        force dut.frame_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.frame_cnt_q;
        i_frame_ready = 1'b1;
        send(32'hF000_0001, 1'b1);
        send(32'hF000_0002, 1'b0);
        send(32'hF000_0003, 1'b0);
        idle(1);
        i_frame_ready = 1'b0;
        n_cmp++;
        if (o_frame_cnt !== 32'd0 || o_drop_cnt !== 16'hFFFF) begin
            n_err++;
            $display("FAIL fcnt_wrap: fcnt=%h drop=%h, expected fcnt=00000000 drop=ffff", o_frame_cnt, o_drop_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_drop_resync();
        test_timeout();
        test_async_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
